// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the MEM-stage SRAM controller.
package sram_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int unsigned BASE_ADDR_DEFAULT = 32'd1024;

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side data-memory bus between the MEM stage and the SRAM controller.
interface sram_ctrl_if;

   logic        rd_en;
   logic        wr_en;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;

   modport master (output rd_en, wr_en, address, wdata, input rdata, ready);
   modport slave  (input rd_en, wr_en, address, wdata, output rdata, ready);

endinterface

// File: rtl/sram_ctrl_wait_counter.sv
// Wait-state counter: counts up from 0 and flags the last cycle of an SRAM phase.
module wait_counter #(
   parameter int unsigned WAIT_CYCLES = 3,
   parameter int unsigned CW          = $clog2(WAIT_CYCLES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   output logic [CW-1:0] cnt,
   output logic          tc
);

   logic [CW-1:0] cnt_r;

   // Count register; saturates at terminal count until cleared.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_r <= '0;
      end else if (!tc) begin
         cnt_r <= cnt_r + CW'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Terminal-count decode.
   always_comb begin
      cnt = cnt_r;
      tc  = (cnt_r == CW'(WAIT_CYCLES - 1));
   end

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage data-memory responder: one 32-bit access becomes two wait-stated
// half-word accesses on an external asynchronous 16-bit SRAM.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 3,
   parameter int unsigned BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   sram_ctrl_if.slave         bus,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic               sram_we_n,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in
);

   localparam int unsigned CW = $clog2(WAIT_CYCLES + 1);
   localparam int unsigned IW = SRAM_AW - 1;

   state_t               state_r;
   logic                 op_wr_r;
   logic [IW-1:0]        idx_r;
   logic [15:0]          wdata_hi_r;
   logic [31:0]          rdata_r;
   logic [SRAM_AW-1:0]   addr_r;
   logic                 we_n_r;
   logic [15:0]          dq_out_r;
   logic                 dq_oe_r;

   logic                 req_s;
   logic [IW-1:0]        idx_s;
   logic                 clr_s;
   logic [CW-1:0]        cnt_s;
   logic                 tc_s;

   wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES),
      .CW          (CW)
   ) u_wait_counter (
      .clk (clk),
      .rst (rst),
      .clr (clr_s),
      .cnt (cnt_s),
      .tc  (tc_s)
   );

   // Request decode, word index, counter clear and the combinational freeze.
   always_comb begin
      req_s       = bus.rd_en | bus.wr_en;
      idx_s       = IW'((bus.address - 32'(BASE_ADDR)) >> 2);
      // Every state change clears the counter; IDLE/DONE keep it parked at 0.
      clr_s       = (state_r == ST_IDLE) | (state_r == ST_DONE) | tc_s;
      bus.ready   = ~req_s | (state_r == ST_DONE);
      bus.rdata   = rdata_r;
      sram_addr   = addr_r;
      sram_we_n   = we_n_r;
      sram_dq_out = dq_out_r;
      sram_dq_oe  = dq_oe_r;
   end

   // Access FSM with registered SRAM pins; pin values are set one edge ahead.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         op_wr_r    <= 1'b0;
         idx_r      <= '0;
         wdata_hi_r <= 16'h0000;
         rdata_r    <= 32'h0000_0000;
         addr_r     <= '0;
         we_n_r     <= 1'b1;
         dq_out_r   <= 16'h0000;
         dq_oe_r    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (req_s) begin
                  state_r    <= ST_LOW;
                  op_wr_r    <= bus.wr_en;
                  idx_r      <= idx_s;
                  wdata_hi_r <= bus.wdata[31:16];
                  addr_r     <= {idx_s, 1'b0};
                  we_n_r     <= ~bus.wr_en;
                  dq_out_r   <= bus.wdata[15:0];
                  dq_oe_r    <= bus.wr_en;
               end
            end
            ST_LOW: begin
               if (tc_s) begin
                  state_r  <= ST_HIGH;
                  addr_r   <= {idx_r, 1'b1};
                  we_n_r   <= ~op_wr_r;
                  dq_out_r <= wdata_hi_r;
                  if (!op_wr_r) begin
                     rdata_r[15:0] <= sram_dq_in;
                  end
               end else begin
                  // WE rises for the final cycle so address/data outlast it.
                  we_n_r <= ~op_wr_r | (cnt_s == CW'(WAIT_CYCLES - 2));
               end
            end
            ST_HIGH: begin
               if (tc_s) begin
                  state_r <= ST_DONE;
                  we_n_r  <= 1'b1;
                  dq_oe_r <= 1'b0;
                  if (!op_wr_r) begin
                     rdata_r[31:16] <= sram_dq_in;
                  end
               end else begin
                  we_n_r <= ~op_wr_r | (cnt_s == CW'(WAIT_CYCLES - 2));
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               we_n_r  <= 1'b1;
               dq_oe_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed, table-driven bench for sram_ctrl against a small behavioural SRAM.
module tb_sram_ctrl;

   localparam int W = 3;

   logic        clk = 1'b0;
   logic        rst;
   logic [17:0] sram_addr;
   logic        sram_we_n;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic [15:0] mem [256];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        rd;
      logic        wr;
      logic        b2b;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [17:0] exp_lo;
   } vec_t;

   vec_t vecs [8];

   sram_ctrl_if bus ();

   sram_ctrl #(
      .WAIT_CYCLES (W),
      .BASE_ADDR   (1024),
      .SRAM_AW     (18)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .sram_addr   (sram_addr),
      .sram_we_n   (sram_we_n),
      .sram_dq_out (sram_dq_out),
      .sram_dq_oe  (sram_dq_oe),
      .sram_dq_in  (sram_dq_in)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: asynchronous read, write while WE low and bus driven.
   assign sram_dq_in = mem[sram_addr[7:0]];
   always @(posedge clk) begin
      if (!sram_we_n && sram_dq_oe) mem[sram_addr[7:0]] <= sram_dq_out;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic go_idle();
      @(negedge clk);
      bus.rd_en = 1'b0;
      bus.wr_en = 1'b0;
      #1;
      check("idle_ready", 32'(bus.ready), 32'd1);
   endtask

   // Drive one request and follow it cycle by cycle until ready rises.
   task automatic run_txn(input vec_t v);
      int   c, frozen, addr_bad, data_bad, oe_bad, we_idle_bad, we_lo, we_hi;
      logic done, in_lo, in_hi, exp_oe;
      c = 0; frozen = 0; addr_bad = 0; data_bad = 0; oe_bad = 0;
      we_idle_bad = 0; we_lo = 0; we_hi = 0; done = 1'b0;
      @(negedge clk);
      bus.rd_en   = v.rd;
      bus.wr_en   = v.wr;
      bus.address = v.addr;
      bus.wdata   = v.wdata;
      while (!done && c < 40) begin
         #1;
         in_lo  = (c >= 1) && (c <= W);
         in_hi  = (c >= W + 1) && (c <= 2 * W);
         exp_oe = (in_lo || in_hi) ? v.wr : 1'b0;
         if (sram_dq_oe !== exp_oe) oe_bad++;
         if (in_lo) begin
            if (sram_addr !== v.exp_lo) addr_bad++;
            if (v.wr && sram_dq_out !== v.wdata[15:0]) data_bad++;
            if (sram_we_n === 1'b0) we_lo++;
         end else if (in_hi) begin
            if (sram_addr !== v.exp_lo + 18'd1) addr_bad++;
            if (v.wr && sram_dq_out !== v.wdata[31:16]) data_bad++;
            if (sram_we_n === 1'b0) we_hi++;
         end else if (sram_we_n !== 1'b1) begin
            we_idle_bad++;
         end
         if (bus.ready === 1'b1) begin
            done = 1'b1;
         end else begin
            frozen++;
            c++;
            @(negedge clk);
         end
      end
      check("latency", 32'(frozen), 32'(2 * W + 1));
      check("addr", 32'(addr_bad), 32'd0);
      check("dq_out", 32'(data_bad), 32'd0);
      check("dq_oe", 32'(oe_bad), 32'd0);
      check("we_n_low_lo", 32'(we_lo), v.wr ? 32'(W - 1) : 32'd0);
      check("we_n_low_hi", 32'(we_hi), v.wr ? 32'(W - 1) : 32'd0);
      check("we_n_idle", 32'(we_idle_bad), 32'd0);
      check("rdata", bus.rdata, v.exp_rdata);
   endtask

   initial begin
      vec_t rv;
      //          rd    wr    b2b   addr         wdata          exp_rdata      exp_lo
      vecs[0] = '{1'b0, 1'b1, 1'b0, 32'd1028,    32'hDEADBEEF, 32'h0000_0000, 18'd2};
      vecs[1] = '{1'b1, 1'b0, 1'b0, 32'd1028,    32'h0000_0000, 32'hDEADBEEF, 18'd2};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 32'd1024,    32'hCAFEF00D, 32'hDEADBEEF, 18'd0};
      vecs[3] = '{1'b1, 1'b0, 1'b1, 32'd1024,    32'h0000_0000, 32'hCAFEF00D, 18'd0};
      vecs[4] = '{1'b1, 1'b1, 1'b0, 32'd1032,    32'h12345678, 32'hCAFEF00D, 18'd4};
      vecs[5] = '{1'b1, 1'b0, 1'b0, 32'd1032,    32'h0000_0000, 32'h12345678, 18'd4};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 32'd525312,  32'h0BADC0DE, 32'h12345678, 18'd0};
      vecs[7] = '{1'b1, 1'b0, 1'b0, 32'd1024,    32'h0000_0000, 32'h0BADC0DE, 18'd0};

      rst         = 1'b1;
      bus.rd_en   = 1'b0;
      bus.wr_en   = 1'b0;
      bus.address = 32'h0000_0000;
      bus.wdata   = 32'h0000_0000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_rdata", bus.rdata, 32'h0000_0000);
      check("rst_sram_addr", 32'(sram_addr), 32'd0);
      check("rst_dq_out", 32'(sram_dq_out), 32'd0);

      for (int i = 0; i < 8; i++) begin
         if (!vecs[i].b2b) go_idle();
         run_txn(vecs[i]);
      end
      go_idle();

      // Reset during the HIGH phase of a read.
      @(negedge clk);
      bus.rd_en   = 1'b1;
      bus.address = 32'd1028;
      repeat (W + 1) @(negedge clk);
      #1;
      check("pre_rst_hi_addr", 32'(sram_addr), 32'd3);
      rst = 1'b1;
      @(negedge clk);
      rst       = 1'b0;
      bus.rd_en = 1'b0;
      #1;
      check("midrst_rdata", bus.rdata, 32'h0000_0000);
      check("midrst_we_n", 32'(sram_we_n), 32'd1);
      check("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
      check("midrst_sram_addr", 32'(sram_addr), 32'd0);
      check("midrst_ready", 32'(bus.ready), 32'd1);

      rv = '{1'b1, 1'b0, 1'b0, 32'd1028, 32'h0000_0000, 32'hDEADBEEF, 18'd2};
      run_txn(rv);
      go_idle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
